// File: rtl/sreg_piso_9x16_bit.sv
// Parallel-in, serial-out frame serializer: one N_OUT x WIDTH frame in, one word per beat out.
// Words leave MSB slice first so a matching SIPO rebuilds the frame bit-exact.
module sreg_piso_9x16_bit #(
    parameter int N_OUT = 9,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_OUT*WIDTH-1:0]   in_parallel,
    output logic [WIDTH-1:0]         out_serial,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     busy
);

    localparam int FW = N_OUT * WIDTH;
    localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_OUT - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          state, state_n;
    logic [FW-1:0]   shreg, shreg_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            load;

    // Handshakes: a beat moves on a side only in a cycle where valid && ready;
    // in_ready in SHIFT opens solely on the final-word transfer so frames chain without bubbles.
    assign out_valid  = (state == SHIFT);
    assign busy       = out_valid;
    assign out_serial = out_valid ? shreg[FW-1 -: WIDTH] : '0;
    assign out_first  = out_valid && (cnt == '0);
    assign out_last   = out_valid && (cnt == LAST_CNT);
    assign in_ready   = (state == IDLE) || (out_last && out_ready);
    assign load       = in_valid && in_ready;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (load) begin
                    shreg_n = in_parallel;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (cnt == LAST_CNT) begin
                        if (in_valid) begin
                            shreg_n = in_parallel;
                            cnt_n   = '0;
                        end else begin
                            shreg_n = '0;
                            cnt_n   = '0;
                            state_n = IDLE;
                        end
                    end else begin
                        shreg_n = {shreg[FW-WIDTH-1:0], {WIDTH{1'b0}}};
                        cnt_n   = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_sreg_piso_9x16_bit.sv
// Scoreboard bench for sreg_piso_9x16_bit: frame driver, random out_ready, monitor with
// expected-word queue plus a frame-level reassembly check.
module tb_sreg_piso_9x16_bit;

  localparam int N  = 9;
  localparam int W  = 16;
  localparam int FW = N * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_parallel;
  logic [W-1:0]  out_serial;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic          busy;

  sreg_piso_9x16_bit #(.N_OUT(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_parallel(in_parallel),
    .out_serial(out_serial),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_first(out_first),
    .out_last(out_last),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: entries are {first, last, word}
  logic [W+1:0]  exp_q[$];
  logic [FW-1:0] frame_q[$];
  logic [FW-1:0] acc;
  int            acc_n;
  int            checks;
  int            failures;
  int            xfer_cnt;
  int            rdy_mode;
  int            rdy_phase;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver: 0 = always high, 1 = pattern 1,0,0, 2 = random
  always @(posedge clk) begin
    #1;
    rdy_phase = (rdy_phase + 1) % 3;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (rdy_phase == 0);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // monitor
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst) begin
      chk("valid_vs_pending", FW'(out_valid), FW'(exp_q.size() != 0));
      chk("busy_eq_valid", FW'(busy), FW'(out_valid));
      if (exp_q.size() == 0) begin
        chk("idle_serial", FW'(out_serial), '0);
        chk("idle_ready", FW'(in_ready), FW'(1));
        chk("idle_flags", FW'({out_first, out_last}), '0);
      end else begin
        e = exp_q[0];
        chk("word", FW'(out_serial), FW'(e[W-1:0]));
        chk("first", FW'(out_first), FW'(e[W+1]));
        chk("last", FW'(out_last), FW'(e[W]));
        chk("in_ready_shift", FW'(in_ready), FW'(e[W] && out_ready));
        if (out_valid && out_ready) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
          acc = {acc[FW-W-1:0], out_serial};
          acc_n++;
          if (acc_n == N) begin
            acc_n = 0;
            if (frame_q.size() != 0) chk("round_trip", acc, frame_q.pop_front());
            else chk("round_trip_extra", FW'(1), '0);
          end
        end
      end
    end
  end

  function automatic logic [FW-1:0] make_frame(input logic [W-1:0] base);
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = base + W'(k);
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom);
    return f;
  endfunction

  // driver: hold the frame until accepted, then record what must come out
  task automatic send_frame(input logic [FW-1:0] f);
    int n;
    in_valid    = 1'b1;
    in_parallel = f;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        chk("accept_timeout", FW'(0), FW'(1));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    for (int k = N - 1; k >= 0; k--) exp_q.push_back({(k == N - 1), (k == 0), f[k*W +: W]});
    frame_q.push_back(f);
    #1;
    in_valid    = 1'b0;
    in_parallel = rand_frame();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", FW'(exp_q.size()), '0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    frame_q.delete();
    acc_n = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int s;
    checks = 0; failures = 0; xfer_cnt = 0; acc = '0; acc_n = 0;
    rdy_mode = 0; rdy_phase = 0;
    rst = 1'b1; in_valid = 1'b0; in_parallel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: single frame, full throughput
    send_frame(make_frame(16'h1000));
    drain();

    // 2: backpressure 1,0,0
    rdy_mode = 1;
    send_frame(make_frame(16'h1000));
    drain();
    rdy_mode = 0;

    // 3: back-to-back, in_valid held high across frames
    send_frame(make_frame(16'hA000));
    send_frame(make_frame(16'hB000));
    drain();

    // 4: new frame offered mid-frame must wait for the final-word transfer
    send_frame(make_frame(16'h2000));
    repeat (4) @(posedge clk);
    #1;
    send_frame(make_frame(16'h3000));
    drain();

    // 5: reset after three transfers aborts the frame
    send_frame(make_frame(16'h4000));
    s = xfer_cnt;
    n = 0;
    while (xfer_cnt < s + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("pre_reset_xfers", FW'(xfer_cnt >= s + 3), FW'(1));
    do_reset();
    @(negedge clk);
    chk("post_rst_valid", FW'(out_valid), '0);
    chk("post_rst_serial", FW'(out_serial), '0);
    chk("post_rst_ready", FW'(in_ready), FW'(1));
    @(posedge clk);
    #1;
    send_frame(make_frame(16'hC000));
    drain();

    // 6: random frames under random backpressure and random upstream gaps
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send_frame(rand_frame());
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 12)) @(posedge clk);
      #1;
    end
    drain();
    rdy_mode = 0;
    drain();

    chk("frames_all_rebuilt", FW'(frame_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
